// File: rtl/count_match.sv
`default_nettype none
// ============================================================================
// Module      : count_match
// Description : Compare/interrupt stage for a free-running counter. Detects
//               the counter stepping onto a programmed compare value and
//               produces a one-cycle match pulse, a sticky irq, a sticky
//               overrun flag and a registered PWM level (count < compare).
//               The compare value is written into a shadow register through
//               a valid/ready port. It moves into the active register at the
//               next counter wrap, or at once while disarmed.
// Ports       : clk        - rising-edge clock
//               reset      - asynchronous active-high reset
//               count      - upstream counter value
//               arm        - enables match detection and PWM
//               cmp_valid  - compare write request
//               cmp_data   - compare write value
//               cmp_ready  - shadow register free (no transfer pending)
//               irq_ack    - clears irq and overrun
//               cmp_active - compare value currently in use
//               match      - one-cycle pulse per match event
//               irq        - sticky match flag
//               overrun    - sticky flag: match while irq still set
//               pwm        - registered PWM level
// Revision    : 1.0 - initial release
// ============================================================================
module count_match #(
    parameter int          N         = 32,
    parameter logic [N-1:0] CMP_RESET = {N{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] count,
    input  logic         arm,
    input  logic         cmp_valid,
    input  logic [N-1:0] cmp_data,
    output logic         cmp_ready,
    input  logic         irq_ack,
    output logic [N-1:0] cmp_active,
    output logic         match,
    output logic         irq,
    output logic         overrun,
    output logic         pwm
);

    logic [N-1:0] r_prev_count;
    logic [N-1:0] r_shadow;
    logic [N-1:0] r_cmp_active;
    logic         r_pending;
    logic         r_match;
    logic         r_irq;
    logic         r_overrun;
    logic         r_pwm;

    logic w_step;
    logic w_wrap;
    logic w_load;
    logic w_xfer;
    logic w_ev;

    // Only a change of count is an event, so a held value fires once.
    assign w_step = (count != r_prev_count);
    assign w_wrap = w_step && (count == '0);

    // Ready comes from the pending register, so a load and a transfer can
    // never coincide.
    assign w_load = cmp_valid && !r_pending;
    assign w_xfer = r_pending && (!arm || w_wrap);

    // Compare against the value in use before any transfer this cycle: a
    // value transferred at a wrap cannot match that same wrap.
    assign w_ev = arm && w_step && (count == r_cmp_active);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_count <= '0;
            r_shadow     <= '0;
            r_cmp_active <= CMP_RESET;
            r_pending    <= 1'b0;
            r_match      <= 1'b0;
            r_irq        <= 1'b0;
            r_overrun    <= 1'b0;
            r_pwm        <= 1'b0;
        end else begin
            r_prev_count <= count;

            if (w_load) begin
                r_shadow  <= cmp_data;
                r_pending <= 1'b1;
            end else if (w_xfer) begin
                r_cmp_active <= r_shadow;
                r_pending    <= 1'b0;
            end

            r_match <= w_ev;

            // A new event wins over a simultaneous acknowledge.
            if (w_ev) begin
                r_irq <= 1'b1;
            end else if (irq_ack) begin
                r_irq <= 1'b0;
            end

            if (w_ev && r_irq && !irq_ack) begin
                r_overrun <= 1'b1;
            end else if (irq_ack) begin
                r_overrun <= 1'b0;
            end

            r_pwm <= arm && (count < r_cmp_active);
        end
    end

    assign cmp_ready  = !r_pending;
    assign cmp_active = r_cmp_active;
    assign match      = r_match;
    assign irq        = r_irq;
    assign overrun    = r_overrun;
    assign pwm        = r_pwm;

endmodule
`default_nettype wire

// File: tb/tb_count_match.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_match
// Description : Directed self-checking bench for count_match (N = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_match;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] count;
    logic         arm;
    logic         cmp_valid;
    logic [N-1:0] cmp_data;
    logic         cmp_ready;
    logic         irq_ack;
    logic [N-1:0] cmp_active;
    logic         match;
    logic         irq;
    logic         overrun;
    logic         pwm;

    int n_tests;
    int n_fail;
    int n_match;

    count_match #(.N(N)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .arm        (arm),
        .cmp_valid  (cmp_valid),
        .cmp_data   (cmp_data),
        .cmp_ready  (cmp_ready),
        .irq_ack    (irq_ack),
        .cmp_active (cmp_active),
        .match      (match),
        .irq        (irq),
        .overrun    (overrun),
        .pwm        (pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input logic [N-1:0] v);
        count = v;
        tick();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        n_match   = 0;
        reset     = 1'b1;
        count     = '0;
        arm       = 1'b0;
        cmp_valid = 1'b0;
        cmp_data  = '0;
        irq_ack   = 1'b0;

        // ---- reset and disarmed state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_match",   match,      0);
        check("rst_irq",     irq,        0);
        check("rst_overrun", overrun,    0);
        check("rst_pwm",     pwm,        0);
        check("rst_ready",   cmp_ready,  1);
        check("rst_active",  cmp_active, 4'hF);

        // ---- write while disarmed: transfers on the following edge
        cmp_valid = 1'b1;
        cmp_data  = 4'd5;
        tick();
        cmp_valid = 1'b0;
        check("dis_ready_low",  cmp_ready,  0);
        check("dis_active_old", cmp_active, 4'hF);
        tick();
        check("dis_active_new", cmp_active, 5);
        check("dis_ready_back", cmp_ready,  1);

        // ---- armed sweep 0..7, three cycles per value
        arm = 1'b1;
        for (int v = 0; v < 8; v++) begin
            count = v[N-1:0];
            for (int k = 0; k < 3; k++) begin
                tick();
                if (match) n_match++;
                check("sweep_pwm", pwm, (v < 5) ? 1 : 0);
                check("sweep_irq", irq, (v >= 5) ? 1 : 0);
                if (k == 0) check("sweep_match", match, (v == 5) ? 1 : 0);
            end
        end
        check("sweep_match_count", n_match, 1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack_irq", irq, 0);

        // ---- armed write is deferred to the wrap
        step_to(4'd0);
        step_to(4'd1);
        step_to(4'd2);
        step_to(4'd3);
        cmp_valid = 1'b1;
        cmp_data  = 4'd2;
        tick();
        cmp_valid = 1'b0;
        check("arm_ready_low", cmp_ready,  0);
        check("arm_active_5",  cmp_active, 5);
        step_to(4'd4);
        step_to(4'd5);
        check("arm_match_5",   match,      1);
        check("arm_still_5",   cmp_active, 5);
        irq_ack = 1'b1;
        step_to(4'd6);
        irq_ack = 1'b0;
        check("arm_ack_irq",   irq,        0);
        step_to(4'd0);
        check("wrap_active_2", cmp_active, 2);
        check("wrap_ready",    cmp_ready,  1);
        check("wrap_no_match", match,      0);
        step_to(4'd1);
        check("pre2_no_match", match,      0);
        step_to(4'd2);
        check("match_2",       match,      1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;

        // ---- overrun with compare = 1
        cmp_valid = 1'b1;
        cmp_data  = 4'd1;
        tick();
        cmp_valid = 1'b0;
        for (int v = 3; v < 16; v++) step_to(v[N-1:0]);
        step_to(4'd0);
        check("ovr_active_1",  cmp_active, 1);
        check("ovr_pwm_0",     pwm,        1);
        step_to(4'd1);
        check("ovr_match1",    match,      1);
        check("ovr_irq1",      irq,        1);
        check("ovr_ovr1",      overrun,    0);
        check("ovr_pwm_1",     pwm,        0);
        for (int v = 2; v < 16; v++) step_to(v[N-1:0]);
        step_to(4'd0);
        step_to(4'd1);
        check("ovr_match2",    match,      1);
        check("ovr_ovr2",      overrun,    1);
        check("ovr_irq2",      irq,        1);
        for (int v = 2; v < 16; v++) step_to(v[N-1:0]);
        step_to(4'd0);
        irq_ack = 1'b1;
        step_to(4'd1);
        irq_ack = 1'b0;
        check("sim_match",     match,      1);
        check("sim_irq_set",   irq,        1);
        check("sim_ovr_clr",   overrun,    0);

        // ---- asynchronous reset while pending and irq set
        cmp_valid = 1'b1;
        cmp_data  = 4'd9;
        tick();
        cmp_valid = 1'b0;
        check("pre_rst_ready", cmp_ready, 0);
        check("pre_rst_irq",   irq,       1);
        #2;
        reset = 1'b1;
        #1;
        check("async_irq",     irq,        0);
        check("async_ready",   cmp_ready,  1);
        check("async_active",  cmp_active, 4'hF);
        check("async_pwm",     pwm,        0);
        count = '0;
        #1;
        reset = 1'b0;
        tick();
        check("post_active",   cmp_active, 4'hF);
        check("post_ready",    cmp_ready,  1);
        check("post_match",    match,      0);
        step_to(4'd9);
        check("post_no_stale", match,      0);
        step_to(4'd15);
        check("post_match_F",  match,      1);
        step_to(4'd0);
        check("post_wrap_act", cmp_active, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_match.md
# count_match

Compare/interrupt stage sitting directly downstream of the prescaled counter: it watches the counter's `count` output and raises a one-cycle `match` pulse and a sticky interrupt whenever the count steps onto a programmed compare value. It also produces a PWM level (`count < compare`). The compare value is written through a valid/ready port into a shadow register. It takes effect glitch-free at the next counter wrap, or immediately while disarmed.

## Interface
Parameters:
- `N`, 32, width of `count` and of the compare registers.
- `CMP_RESET`, {N{1'b1}}, reset value of the active compare register.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `count`  in  N  counter value from the upstream counter; synchronous to `clk`.
- `arm`  in  1  enables match detection and the PWM output.
- `cmp_valid`  in  1  compare-write request.
- `cmp_data`  in  N  compare value; sampled when `cmp_valid && cmp_ready`.
- `cmp_ready`  out  1  shadow register free (equals `!pending`).
- `irq_ack`  in  1  clears `irq` and `overrun`.
- `cmp_active`  out  N  compare value currently in use.
- `match`  out  1  one-cycle pulse per match event.
- `irq`  out  1  sticky match flag.
- `overrun`  out  1  sticky flag: a match occurred while `irq` was still set.
- `pwm`  out  1  registered PWM level.

## Operation
- **Step detection:** `prev_count` register (reset 0) loads `count` every cycle. `step = (count != prev_count)`. Only steps are events; a `count` held for many cycles yields one event.
- **Wrap:** `wrap = step && (count == 0)`. Upstream counter reset to 0 also counts as a wrap.
- **Shadow load:** on `cmp_valid && cmp_ready`, `shadow <= cmp_data` and `pending <= 1`. `cmp_ready` is `!pending` from a register, not combinational from `cmp_valid`. `cmp_data` is ignored when not ready.
- **Transfer:** when `pending && (!arm || wrap)`, `cmp_active <= shadow` and `pending <= 0`. A load and a transfer cannot occur in the same cycle because `cmp_ready` is 0 while pending.
- **Match event:** `ev = arm && step && (count == cmp_active)`. The comparison uses `cmp_active` before any transfer in the same cycle, so a compare value transferred at a wrap never matches that same wrap cycle.
- **Match outputs:** `match <= ev`.
- **irq:** set on `ev`, cleared on `irq_ack`. Set wins when `ev` and `irq_ack` occur in the same cycle.
- **overrun:** set on `ev && irq && !irq_ack`, cleared on `irq_ack`.
- **PWM:** `pwm <= arm && (count < cmp_active)`. Unsigned N-bit compare.
- **Disarming:** deasserting `arm` suppresses new events and forces `pwm` to 0 next cycle. `irq` and `overrun` hold their values.

## Timing
- **Reset values:**
  - `cmp_active = CMP_RESET`, shadow 0, `pending = 0` (so `cmp_ready = 1`).
  - `match`, `irq`, `overrun`, `pwm` all 0.
  - `prev_count = 0`.
- **Reset mid-operation:** reset applies immediately (async). Any pending shadow value is discarded.
- **Latency:** `match`, `irq`, `overrun` and `pwm` rise one clock after the cycle in which `count` presents the triggering value.
- **Handshake:**
  - A write completes on the edge where `cmp_valid && cmp_ready`.
  - `cmp_ready` drops on the next cycle and stays low until the transfer edge.
  - `cmp_ready` is back at 1 on the cycle after the transfer.
- **Wrap-around:** `count` going from 2^N−1 to 0 is a wrap. A compare value of 0 matches on every wrap once it is active.

## Test plan
- **Reset and arming:** hold `reset`, release; `arm = 0` → all outputs 0, `cmp_ready = 1`, `cmp_active = 0xFFFFFFFF`.
- **Write while disarmed, then match:** with `arm = 0`, write 5 → `cmp_active = 5` two edges after the write. Then set `arm = 1` and step `count` 0..7, each value held 3 cycles → exactly one `match` pulse, one cycle after `count` becomes 5. `irq = 1` until `irq_ack`. `pwm = 1` while `count` is 0..4.
- **Armed write defers to wrap:** armed with `cmp_active = 5`, write 2 at `count = 3` → `cmp_ready = 0`, match still fires at 5. At wrap to 0, `cmp_active` becomes 2 and `cmp_ready` returns to 1. The next match is at 2.
- **Overrun and simultaneous events:** with `cmp_active = 1`, wrap `count` (`N = 4`) twice without ack → `overrun = 1` after the second match. `irq_ack` on the same cycle as a new `ev` → `irq` stays 1 and `overrun` clears.
- **Reset mid-operation:** assert async `reset` mid-cycle while `pending = 1` and `irq = 1` → outputs return to reset values immediately, without waiting for a clock edge. After release, no stale transfer or match occurs.
